// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned shift-add multiplier with private HI/LO result registers.
// One product bit per clock; MFHI/MFLO read the last completed result combinationally.
module multu_hilo (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    localparam int unsigned W      = 32;
    localparam int unsigned PW     = 2 * W;
    localparam int unsigned CW     = 5;
    localparam logic [5:0]  MULTU  = 6'b011001;
    localparam logic [5:0]  MFHI   = 6'b010000;
    localparam logic [5:0]  MFLO   = 6'b010010;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            accept;
    logic [W:0]      sum;

    // A new multiply may only be taken when no iteration is in flight.
    assign accept = start && (Signal == MULTU) && (state_q != ST_RUN);

    // Carry must be kept: it becomes bit 63 after the shift.
    assign sum = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : (W+1)'(0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    mcand_d = dataA;
                    prod_d  = {W'(0), dataB};
                    count_d = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                prod_d  = {sum, prod_q[W-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    hi_d    = prod_d[PW-1:W];
                    lo_d    = prod_d[W-1:0];
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // Read port: zero-latency select of the held result, blanked during reset.
    always_comb begin
        dataOut = '0;
        if (reset) begin
            if (Signal == MFHI) begin
                dataOut = hi_q;
            end else if (Signal == MFLO) begin
                dataOut = lo_q;
            end
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: directed scenarios with literal results plus
// randomized traffic checked every cycle against a cycle-count/product reference model.
module tb_multu_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_ADD   = 6'd32;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining run cycles, latched operands, held result.
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_prod;

    always @(posedge clk) begin
        if (!reset) begin
            m_left = 0;
            m_done = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 0;
            if (m_left != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_prod = 64'(m_a) * 64'(m_b);
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                    m_done = 1;
                end
            end else if (start && Signal == OP_MULTU) begin
                m_a    = dataA;
                m_b    = dataB;
                m_left = 32;
            end
        end
    end

    function automatic logic [31:0] exp_out();
        if (!reset)                return 32'h0;
        else if (Signal == OP_MFHI) return m_hi;
        else if (Signal == OP_MFLO) return m_lo;
        else                        return 32'h0;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks = checks + 3;
            if (busy !== (m_left != 0)) begin
                errors = errors + 1;
                $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, (m_left != 0));
            end
            if (done !== m_done) begin
                errors = errors + 1;
                $display("FAIL mon_done t=%0t got=%b exp=%b", $time, done, m_done);
            end
            if (dataOut !== exp_out()) begin
                errors = errors + 1;
                $display("FAIL mon_dataOut t=%0t sig=%0d got=%h exp=%h", $time, Signal, dataOut, exp_out());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = OP_MULTU;
        dataA  = a;
        dataB  = b;
        step();
        start  = 1'b0;
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] hi, input logic [31:0] lo);
        Signal = OP_MFHI;
        @(negedge clk);
        chk({nm, "_hi"}, dataOut, hi);
        Signal = OP_MFLO;
        @(negedge clk);
        chk({nm, "_lo"}, dataOut, lo);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks = checks + 1;
        if (!seen) begin
            errors = errors + 1;
            $display("FAIL %s_timeout got=no_done exp=done_within_40", nm);
        end
        step();
    endtask

    initial begin
        int nbusy;
        int ndone;
        reset  = 1'b0;
        start  = 1'b0;
        Signal = 6'd0;
        dataA  = '0;
        dataB  = '0;
        step();
        mon_en = 1;
        step();
        reset = 1'b1;
        step();

        // Reset state
        read_hilo("reset", 32'h0, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // 7 x 6: busy exactly 32 cycles, one done pulse
        issue(32'd7, 32'd6);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) ndone++;
        end
        chk("busy_cycles", 32'(nbusy), 32'd32);
        chk("done_pulses", 32'(ndone), 32'd1);
        step();
        read_hilo("mul7x6", 32'h0, 32'h0000002A);

        // Full-scale operands exercise the adder carry
        issue(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("mulmax");
        read_hilo("mulmax", 32'hFFFFFFFE, 32'h00000001);

        // Mid-run restart and non-MULTU start are ignored
        issue(32'd3, 32'd5);
        repeat (4) step();
        start = 1'b1; Signal = OP_MULTU; dataA = 32'd9; dataB = 32'd9;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1; Signal = OP_ADD;
        step();
        start = 1'b0;
        wait_done("mul3x5");
        read_hilo("mul3x5", 32'h0, 32'h0000000F);

        // Previous result visible while busy
        issue(32'h12345678, 32'h00000010);
        Signal = OP_MFLO;
        @(negedge clk);
        chk("lo_while_busy", dataOut, 32'h0000000F);
        wait_done("mulshift");
        read_hilo("mulshift", 32'h00000001, 32'h23456780);

        // Reset mid-run discards the multiply
        issue(32'hABCD, 32'h1234);
        repeat (9) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        read_hilo("rst_mid", 32'h0, 32'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'h0);
        step();

        // Back-to-back: start held through RUN is taken in the DONE cycle
        issue(32'd2, 32'd3);
        start = 1'b1; Signal = OP_MULTU; dataA = 32'h00010000; dataB = 32'h00010000;
        repeat (32) step();
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'h1);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done("b2b");
        read_hilo("b2b", 32'h00000001, 32'h00000000);

        // Randomized traffic, checked by the per-cycle monitor
        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: Signal = OP_MULTU;
                1: Signal = OP_MFHI;
                2: Signal = OP_MFLO;
                default: Signal = 6'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: dataA = $urandom;
                1: dataA = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
                default: dataA = 32'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 2))
                0: dataB = $urandom;
                1: dataB = 32'h80000000 | $urandom;
                default: dataB = 32'($urandom_range(0, 255));
            endcase
            step();
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32×32 unsigned multiplier with its own HI/LO result registers. It sits beside the 32-bit ALU on the execute stage. It takes the same dataA/dataB operand buses and the same 6-bit function code (Signal). Its dataOut feeds the execute-stage result mux next to the ALU output. The product is computed by the shift-add algorithm with a 64-bit product register, one bit per clock, and is read back with MFHI/MFLO.

## Interface
- MULTU, 6'b011001, function code that starts a multiply (25)
- MFHI, 6'b010000, function code that reads HI (16)
- MFLO, 6'b010010, function code that reads LO (18)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- start  in  1  request strobe; sampled on rising edge
- dataA  in  32  multiplicand
- dataB  in  32  multiplier
- Signal  in  6  function code (MULTU / MFHI / MFLO; others ignored)
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: HI/LO just updated
- dataOut  out  32  HI if Signal==MFHI, LO if Signal==MFLO, else 0

## Operation
- Registers:
  - state {IDLE, RUN, DONE}
  - mcand[31:0]
  - prod[63:0]
  - count[4:0]
  - HI[31:0]
  - LO[31:0]
- Reset (reset==0 at an edge), from any state, including mid-RUN:
  - state=IDLE; mcand, prod, count, HI and LO all 0.
  - Any in-flight multiply is discarded; no done pulse.
- Accept: start==1 && Signal==MULTU && state∈{IDLE, DONE}.
  - mcand<=dataA; prod<={32'b0, dataB}; count<=0; state<=RUN.
- start with any other Signal is ignored. start while in RUN is ignored; operands are not re-latched.
- RUN, each edge:
  - sum[32:0] = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'b0).
  - prod <= {sum[32:0], prod[31:1]} (shift right 1, carry into bit 63).
  - count <= count+1.
- RUN exit: the edge with count==31 is the 32nd iteration.
  - Same edge: HI<=next_prod[63:32], LO<=next_prod[31:0], state<=DONE.
- DONE: lasts exactly one cycle.
  - Next edge goes to RUN if accept holds, else IDLE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - dataOut is combinational from HI/LO and Signal.
  - dataOut is forced 0 while reset==0.
- HI/LO hold the last completed product. They are unchanged during RUN, so MFHI/MFLO issued while busy return the previous result.
- Arithmetic is unsigned only; 64-bit result, no overflow.
- Adder carry must be kept (33-bit sum). Dropping it corrupts results with operands ≥ 2^31.

## Timing
- Output values after reset edge: busy=0, done=0, dataOut=0 for every Signal.
- Start sampled at edge E:
  - busy=1 in the 32 cycles following edges E..E+31.
  - done=1 in the single cycle following edge E+32.
  - HI/LO hold the new product from edge E+32 onward.
- Latency from start edge to result: 32 clocks. Throughput: one multiply per 33 clocks.
- A back-to-back start in the DONE cycle is accepted at edge E+33, with no idle cycle.
- Simultaneous reset==0 and start==1: reset wins.
- Signal change during RUN does not affect the operation. Signal only selects dataOut and qualifies start.
- dataOut has zero-cycle latency from Signal (combinational mux on registered HI/LO).

## Test plan
- Reset, then Signal=MFHI and Signal=MFLO -> dataOut=0x00000000 both; busy=0, done=0.
- start, Signal=MULTU, dataA=7, dataB=6 at edge E -> busy high for 32 cycles; done pulses once after E+32; MFLO=0x0000002A, MFHI=0.
- dataA=dataB=0xFFFFFFFF -> MFHI=0xFFFFFFFE, MFLO=0x00000001 (exercises carry into bit 63).
- Mid-run and illegal requests, during a multiply of 3×5:
  - At RUN cycle 5: start with dataA=9, dataB=9. At cycle 8: start with Signal=ADD (32).
  - Required: both ignored; result MFLO=0x0000000F, done pulses once.
- Previous result 3×5 held; start 0x12345678×0x10 -> MFLO reads 0x0000000F while busy, then 0x23456780 after done; MFHI=0x00000001.
- reset=0 at RUN cycle 10 -> next cycle busy=0, done=0, MFLO/MFHI=0, no later done.
- Back-to-back: start 0x00010000×0x00010000 held in the DONE cycle of the previous op -> accepted with no idle cycle; MFHI=0x00000001, MFLO=0x00000000.
